// File: rtl/pcileech_tx_arbiter_pkg.sv
// Shared types and helpers for the FPGA->host TX arbiter.
package pcileech_tx_arbiter_pkg;

  localparam int unsigned SRC_TLP  = 0;
  localparam int unsigned SRC_CFG  = 1;
  localparam int unsigned SRC_CORE = 2;
  localparam int unsigned SRC_LOOP = 3;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned MAX_SRC = 4;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
    logic              last;
  } arb_word_t;

  // Returns {found, index} of the first requester at or after ptr, wrapping at n.
  function automatic logic [SRC_W:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                             input logic [SRC_W-1:0]   ptr,
                                             input int unsigned        n);
    logic [SRC_W:0]   res;
    logic [SRC_W-1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_SRC; k++) begin
      idx = SRC_W'((32'(ptr) + k) % n);
      if (k < n && !res[SRC_W] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/pcileech_tx_arbiter_if.sv
// Producer-side and com-side handshake bundle for the TX arbiter.
interface pcileech_tx_arbiter_if #(
  parameter int unsigned NUM_SRC = 3
);
  import pcileech_tx_arbiter_pkg::*;

  logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0]             src_last;
  logic [NUM_SRC-1:0]             src_ready;
  logic [DATA_W-1:0]              out_data;
  logic [SRC_W-1:0]               out_src;
  logic                           out_last;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    input  src_data, src_valid, src_last, out_ready,
    output src_ready, out_data, out_src, out_last, out_valid
  );

  modport slave (
    output src_data, src_valid, src_last, out_ready,
    input  src_ready, out_data, out_src, out_last, out_valid
  );

endinterface

// File: rtl/pcileech_tx_arbiter_skid.sv
// Two-entry registered skid buffer; in_ready depends only on occupancy.
module pcileech_tx_arbiter_skid
  import pcileech_tx_arbiter_pkg::*;
#(
  parameter int unsigned W = $bits(arb_word_t)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcileech_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing the 32-bit com TX path between NUM_SRC producers.
module pcileech_tx_arbiter
  import pcileech_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned PKTS_PER_GRANT = 4,
  parameter int unsigned STALL_TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  pcileech_tx_arbiter_if.master bus,
  output logic                  grant_active,
  output logic                  err_stall
);

  localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT + 1);

  arb_state_t                       state;
  logic [SRC_W-1:0]                 grant;
  logic [SRC_W-1:0]                 rr_ptr;
  logic [7:0]                       pkt_cnt;
  logic [STALL_W-1:0]               stall_cnt;
  logic                             at_boundary;

  logic [MAX_SRC-1:0]               req;
  logic [MAX_SRC-1:0]               last_pad;
  logic [MAX_SRC-1:0][DATA_W-1:0]   data_pad;
  logic [MAX_SRC-1:0]               ready_pad;
  logic [SRC_W:0]                   pick;
  logic [SRC_W-1:0]                 next_rr;
  logic                             skid_ready;
  logic                             accept;
  logic                             others_waiting;
  logic                             limit_hit;
  arb_word_t                        skid_in;
  arb_word_t                        skid_out;

  // Pad per-source vectors to MAX_SRC so the grant index is always in range.
  always_comb begin
    req      = MAX_SRC'(bus.src_valid);
    last_pad = MAX_SRC'(bus.src_last);
    data_pad = (MAX_SRC * DATA_W)'(bus.src_data);
  end

  always_comb begin
    ready_pad        = '0;
    ready_pad[grant] = (state == ARB_LOCK) & skid_ready;
    bus.src_ready    = ready_pad[NUM_SRC-1:0];
  end

  assign pick           = rr_pick(req, rr_ptr, NUM_SRC);
  assign next_rr        = (32'(grant) + 32'd1 == NUM_SRC) ? '0 : grant + 1'b1;
  assign accept         = (state == ARB_LOCK) & skid_ready & req[grant];
  assign others_waiting = |(req & ~(MAX_SRC'(1) << grant));
  assign limit_hit      = (32'(pkt_cnt) + 32'd1 >= PKTS_PER_GRANT);

  always_comb begin
    skid_in.src  = grant;
    skid_in.data = data_pad[grant];
    skid_in.last = last_pad[grant];
  end

  pcileech_tx_arbiter_skid #(
    .W($bits(arb_word_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (skid_in),
    .in_valid (accept),
    .in_ready (skid_ready),
    .out_data (skid_out),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready)
  );

  assign bus.out_src  = skid_out.src;
  assign bus.out_data = skid_out.data;
  assign bus.out_last = skid_out.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      pkt_cnt      <= '0;
      stall_cnt    <= '0;
      at_boundary  <= 1'b1;
      grant_active <= 1'b0;
      err_stall    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick[SRC_W]) begin
            grant        <= pick[SRC_W-1:0];
            pkt_cnt      <= '0;
            stall_cnt    <= '0;
            at_boundary  <= 1'b1;
            state        <= ARB_LOCK;
            grant_active <= 1'b1;
          end
        end
        ARB_LOCK: begin
          if (accept) begin
            stall_cnt   <= '0;
            at_boundary <= last_pad[grant];
            // At the per-grant limit only a competing requester forces rotation;
            // a lone requester restarts its count and keeps the lock.
            if (last_pad[grant]) begin
              if (limit_hit) begin
                pkt_cnt <= '0;
                if (others_waiting) begin
                  rr_ptr       <= next_rr;
                  state        <= ARB_IDLE;
                  grant_active <= 1'b0;
                end
              end else begin
                pkt_cnt <= pkt_cnt + 1'b1;
              end
            end
          end else if (!req[grant]) begin
            if (at_boundary) begin
              rr_ptr       <= next_rr;
              state        <= ARB_IDLE;
              grant_active <= 1'b0;
            end else begin
              if (32'(stall_cnt) + 32'd1 >= STALL_TIMEOUT) err_stall <= 1'b1;
              if (32'(stall_cnt) < STALL_TIMEOUT) stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// Randomized and directed checks of the TX arbiter against per-source packet queues.
module tb_pcileech_tx_arbiter;
  import pcileech_tx_arbiter_pkg::*;

  localparam int NS  = 3;
  localparam int PPG = 4;
  localparam int STO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant_active;
  logic err_stall;

  pcileech_tx_arbiter_if #(.NUM_SRC(NS)) bus();

  pcileech_tx_arbiter #(
    .NUM_SRC       (NS),
    .PKTS_PER_GRANT(PPG),
    .STALL_TIMEOUT (STO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_active(grant_active),
    .err_stall   (err_stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] q_send [NS][$];
  logic [32:0] exp_q  [NS][$];
  int          sent    [NS];
  int          stop_at [NS];
  int          pkt_srcs [$];
  int          out_times [$];
  int          cyc = 0;
  int          occ = 0;
  int          gap_pct = 0;
  int          ordy_mode = 0;
  logic        in_pkt = 1'b0;
  logic [1:0]  cur_src = '0;
  logic        hold_v = 1'b0;
  logic [34:0] hold_word = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NS; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic push_pkt(input int s, input int len);
    logic [32:0] w;
    for (int k = 0; k < len; k++) begin
      w = {(k == len - 1), $urandom()};
      q_send[s].push_back(w);
      exp_q[s].push_back(w);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) begin
      q_send[i].delete();
      exp_q[i].delete();
      stop_at[i] = -1;
    end
    in_pkt = 1'b0;
    occ    = 0;
    hold_v = 1'b0;
  endtask

  task automatic clear_log();
    pkt_srcs.delete();
    out_times.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (q_send[i].size() > 0 && sent[i] != stop_at[i] &&
          int'($urandom_range(99)) >= gap_pct) begin
        bus.src_valid[i] = 1'b1;
        bus.src_last[i]  = q_send[i][0][32];
        bus.src_data[i]  = q_send[i][0][31:0];
      end else begin
        bus.src_valid[i] = 1'b0;
        bus.src_last[i]  = 1'($urandom_range(1));
        bus.src_data[i]  = $urandom();
      end
    end
    case (ordy_mode)
      1:       bus.out_ready = (cyc % 2 == 0);
      2:       bus.out_ready = ($urandom_range(99) < 70);
      default: bus.out_ready = 1'b1;
    endcase
  endtask

  task automatic model_out();
    int  s;
    logic ok;
    s  = int'(bus.out_src);
    if (in_pkt) check("no_interleave", bus.out_src, cur_src);
    ok = (s < NS) && (exp_q[s].size() > 0);
    check("src_has_pending", ok, 1);
    if (ok) begin
      check("word", {bus.out_last, bus.out_data}, exp_q[s][0]);
      void'(exp_q[s].pop_front());
    end
    out_times.push_back(cyc);
    if (bus.out_last) begin
      pkt_srcs.push_back(s);
      in_pkt = 1'b0;
    end else begin
      in_pkt  = 1'b1;
      cur_src = bus.out_src;
    end
  endtask

  task automatic sample();
    logic [NS-1:0] acc;
    logic          fire;
    acc  = bus.src_valid & bus.src_ready;
    fire = bus.out_valid & bus.out_ready;
    check("ready_onehot0", $onehot0(bus.src_ready), 1);
    if (occ == 2) check("ready_when_full", bus.src_ready, 0);
    if (hold_v) check("out_hold", {bus.out_valid, bus.out_src, bus.out_last, bus.out_data},
                      {1'b1, hold_word});
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        void'(q_send[i].pop_front());
        sent[i]++;
      end
    end
    if (fire) model_out();
    occ    = occ + $countones(acc) - int'(fire);
    hold_v = bus.out_valid & ~bus.out_ready;
    hold_word = {bus.out_src, bus.out_last, bus.out_data};
  endtask

  task automatic cycle();
    drive();
    #1;
    sample();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n = 0;
    while ((pending() > 0 || occ > 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, pending(), 0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    flush();
    drive();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < NS; i++) begin
      stop_at[i] = -1;
      sent[i]    = 0;
    end
    drive();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_src", bus.out_src, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_grant_active", grant_active, 0);
    check("rst_err_stall", err_stall, 0);
    rst = 1'b0;
    @(negedge clk);

    // Lone source: three 4-word packets, no gaps once streaming.
    clear_log();
    for (int p = 0; p < 3; p++) push_pkt(0, 4);
    drain(200, "t1");
    check("t1_words", out_times.size(), 12);
    check("t1_pkts", pkt_srcs.size(), 3);
    foreach (pkt_srcs[k]) check("t1_src", pkt_srcs[k], 0);
    if (out_times.size() == 12) check("t1_span", out_times[11] - out_times[0], 11);

    // All sources busy: PPG packets per grant, one bubble per rotation.
    reset_pulse();
    clear_log();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < 8; p++) push_pkt(s, 2);
    drain(500, "t2");
    check("t2_pkts", pkt_srcs.size(), 24);
    foreach (pkt_srcs[k]) check("t2_order", pkt_srcs[k], (k / PPG) % NS);
    if (out_times.size() == 48) check("t2_bubbles", out_times[47] - out_times[0] + 1 - 48, 5);

    // Late second requester must not split an in-flight packet.
    reset_pulse();
    clear_log();
    push_pkt(0, 8);
    cycle();
    cycle();
    push_pkt(1, 4);
    drain(200, "t3");
    check("t3_pkts", pkt_srcs.size(), 2);
    if (pkt_srcs.size() == 2) begin
      check("t3_first", pkt_srcs[0], 0);
      check("t3_second", pkt_srcs[1], 1);
    end
    if (out_times.size() == 12) check("t3_contig", out_times[7] - out_times[0], 7);

    // Alternating backpressure on a 16-word packet.
    reset_pulse();
    clear_log();
    ordy_mode = 1;
    push_pkt(0, 16);
    drain(300, "t4");
    check("t4_words", out_times.size(), 16);
    ordy_mode = 0;

    // Mid-packet stall trips the sticky watchdog; the packet still completes.
    reset_pulse();
    clear_log();
    push_pkt(0, 5);
    stop_at[0] = sent[0] + 2;
    n = 0;
    while (sent[0] != stop_at[0] && n < 50) begin
      cycle();
      n++;
    end
    check("t5_reached_word2", sent[0], stop_at[0]);
    repeat (STO - 4) cycle();
    check("t5_err_early", err_stall, 0);
    repeat (5) cycle();
    check("t5_err_set", err_stall, 1);
    check("t5_still_locked", grant_active, 1);
    stop_at[0] = -1;
    drain(100, "t5");
    check("t5_words", out_times.size(), 5);
    check("t5_err_sticky", err_stall, 1);

    // Reset in the middle of a src1 packet while the round-robin pointer is nonzero.
    clear_log();
    push_pkt(0, 1);
    drain(50, "t6a");
    push_pkt(1, 6);
    base = sent[1];
    n = 0;
    while (sent[1] < base + 3 && n < 50) begin
      cycle();
      n++;
    end
    check("t6_reached_word3", sent[1], base + 3);
    reset_pulse();
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_src_ready", bus.src_ready, 0);
    check("t6_grant_active", grant_active, 0);
    check("t6_err_stall", err_stall, 0);
    clear_log();
    push_pkt(1, 2);
    push_pkt(0, 2);
    drain(100, "t6");
    check("t6_pkts", pkt_srcs.size(), 2);
    if (pkt_srcs.size() > 0) check("t6_rr_from_zero", pkt_srcs[0], 0);

    // Random traffic, random source gaps and random backpressure.
    clear_log();
    gap_pct   = 25;
    ordy_mode = 2;
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < 10; p++) push_pkt(s, int'($urandom_range(6, 1)));
    drain(5000, "t7");
    check("t7_pkts", pkt_srcs.size(), 30);
    gap_pct   = 0;
    ordy_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
